// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the instruction-memory arbiter.
// Owner encoding, request bundle and the word-address range check.
package imem_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } imem_req_t;

  // Word aligned and inside 0 .. 4*n_instr-1
  function automatic logic addr_ok(
    input logic [XLEN-1:0] addr,
    input int unsigned     n_instr
  );
    logic [63:0] lim;
    lim = 64'(n_instr) << 2;
    return (addr[1:0] == 2'b00) &&
           ({32'd0, addr} < lim);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, fetch wins the first tie.
// Ports: clk, rstn, req_f/req_l in; gnt_f/gnt_l out (same cycle).
module rr_arb2
  import imem_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic req_f,
  input  logic req_l,
  output logic gnt_f,
  output logic gnt_l
);

  owner_e rr_last;

  always_comb begin
    gnt_f = 1'b0;
    gnt_l = 1'b0;
    unique case ({req_f, req_l})
      2'b11: begin
        if (rr_last == OWN_LOADER)
          gnt_f = 1'b1;
        else
          gnt_l = 1'b1;
      end
      2'b10:   gnt_f = 1'b1;
      2'b01:   gnt_l = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rr_last <= OWN_LOADER;
    else if (gnt_f | gnt_l)
      rr_last <= gnt_l ? OWN_LOADER : OWN_FETCH;
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one registered-read memory port between
// fetch (read) and loader (read/write); responses one cycle after grant.
// Ports: f_* fetch side, l_* loader side (l_lock blocks fetch),
// mem_* memory side; clk, rstn (async, active low).
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int N       = 32,
  parameter int N_INSTR = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          f_req,
  input  logic [N-1:0]  f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [N-1:0]  f_rdata,
  output logic          f_err,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [N-1:0]  l_addr,
  input  logic [N-1:0]  l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [N-1:0]  l_rdata,
  output logic          l_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [$clog2(N_INSTR)-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata
);

  localparam int AW = $clog2(N_INSTR);

  logic      elig_f;
  logic      elig_l;
  logic      acc;
  logic      ok;
  imem_req_t sel;

  logic      resp_vld;
  owner_e    resp_owner;
  logic      resp_err;
  logic      resp_rd;

  // Nothing is granted while reset is held
  assign elig_f = f_req & ~l_lock & rstn;
  assign elig_l = l_req & rstn;

  rr_arb2 u_rr (
    .clk   (clk),
    .rstn  (rstn),
    .req_f (elig_f),
    .req_l (elig_l),
    .gnt_f (f_gnt),
    .gnt_l (l_gnt)
  );

  always_comb begin
    sel = '0;
    if (l_gnt) begin
      sel.we    = l_we;
      sel.addr  = l_addr;
      sel.wdata = l_wdata;
    end else begin
      sel.we    = 1'b0;
      sel.addr  = f_addr;
      sel.wdata = '0;
    end
  end

  assign acc       = f_gnt | l_gnt;
  assign ok        = addr_ok(sel.addr, N_INSTR);
  assign mem_en    = acc & ok;
  assign mem_we    = mem_en & sel.we;
  assign mem_addr  = sel.addr[AW+1:2];
  assign mem_wdata = sel.wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_vld   <= 1'b0;
      resp_owner <= OWN_FETCH;
      resp_err   <= 1'b0;
      resp_rd    <= 1'b0;
    end else begin
      resp_vld   <= acc;
      resp_owner <= l_gnt ? OWN_LOADER : OWN_FETCH;
      resp_err   <= acc & ~ok;
      resp_rd    <= acc & ok & ~sel.we;
    end
  end

  // Read data only passes through for error-free reads
  always_comb begin
    f_rvalid = resp_vld & (resp_owner == OWN_FETCH);
    l_rvalid = resp_vld & (resp_owner == OWN_LOADER);
    f_err    = f_rvalid & resp_err;
    l_err    = l_rvalid & resp_err;
    f_rdata  = (f_rvalid & resp_rd) ? mem_rdata : '0;
    l_rdata  = (l_rvalid & resp_rd) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed plus random stimulus for imem_arbiter,
// checked every cycle against a transaction-level reference.
module tb_imem_arbiter;

  localparam int N  = 32;
  localparam int NI = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          f_req;
  logic [N-1:0]  f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [N-1:0]  f_rdata;
  logic          f_err;
  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [N-1:0]  l_addr;
  logic [N-1:0]  l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [N-1:0]  l_rdata;
  logic          l_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.N(N), .N_INSTR(NI)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .f_err     (f_err),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_lock    (l_lock),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .l_err     (l_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory attached to the port
  logic [N-1:0] mem [NI];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        mem[mem_addr] <= mem_wdata;
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  // Reference state
  logic [N-1:0] ref_mem [NI];
  bit           last_l;
  bit           pv;
  bit           po;
  bit           pe;
  logic [N-1:0] pd;
  bit           got_f;
  bit           got_l;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [N-1:0] a);
    return (a % 4 == 0) && (64'(a) < 64'(4 * NI));
  endfunction

  // Inputs are applied just after a negedge; check, then advance model
  task automatic step();
    bit           ef, el, gf, gl, ok, wr;
    logic [N-1:0] a;
    #1;
    chk("f_rvalid", 64'(f_rvalid), 64'(pv && !po));
    chk("l_rvalid", 64'(l_rvalid), 64'(pv && po));
    chk("f_err", 64'(f_err), 64'(pv && !po && pe));
    chk("l_err", 64'(l_err), 64'(pv && po && pe));
    chk("f_rdata", 64'(f_rdata), 64'((pv && !po) ? pd : '0));
    chk("l_rdata", 64'(l_rdata), 64'((pv && po) ? pd : '0));

    ef = f_req && !l_lock;
    el = l_req;
    gf = ef && (!el || last_l);
    gl = el && !gf;
    chk("f_gnt", 64'(f_gnt), 64'(gf));
    chk("l_gnt", 64'(l_gnt), 64'(gl));

    a  = gl ? l_addr : f_addr;
    ok = in_range(a);
    wr = gl && l_we;
    chk("mem_en", 64'(mem_en), 64'((gf || gl) && ok));
    if ((gf || gl) && ok) begin
      chk("mem_we", 64'(mem_we), 64'(wr));
      chk("mem_addr", 64'(mem_addr), 64'(a / 4));
      if (wr)
        chk("mem_wdata", 64'(mem_wdata), 64'(l_wdata));
    end

    pv = gf || gl;
    po = gl;
    pe = !ok;
    pd = (pv && ok && !wr) ? ref_mem[a / 4] : '0;
    if (pv && ok && wr)
      ref_mem[a / 4] = l_wdata;
    if (pv)
      last_l = gl;
    got_f = gf;
    got_l = gl;
    @(negedge clk);
  endtask

  task automatic idle();
    f_req  = 1'b0;
    l_req  = 1'b0;
    l_we   = 1'b0;
    l_lock = 1'b0;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    f_req = 1'b1;
    l_req = 1'b1;
    f_addr = 32'h0;
    l_addr = 32'h4;
    #1;
    chk("rst_f_gnt", 64'(f_gnt), 64'(0));
    chk("rst_l_gnt", 64'(l_gnt), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_f_rvalid", 64'(f_rvalid), 64'(0));
    chk("rst_l_rvalid", 64'(l_rvalid), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle();
    last_l = 1'b1;
    pv = 1'b0;
    pd = '0;
  endtask

  function automatic logic [N-1:0] gen_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)
      return 32'($urandom_range(0, NI - 1) * 4);
    else if (r == 8)
      return 32'($urandom_range(0, NI - 1) * 4 +
                 $urandom_range(1, 3));
    else
      return 32'(4 * NI + $urandom_range(0, 64));
  endfunction

  initial begin
    for (int i = 0; i < NI; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem_rdata = '0;
    f_addr  = '0;
    l_addr  = '0;
    l_wdata = '0;
    idle();
    rstn = 1'b1;
    last_l = 1'b1;
    pv = 1'b0;
    pd = '0;
    @(negedge clk);

    do_reset();

    // Tie from reset: F, L, F, L
    f_req = 1'b1;
    l_req = 1'b1;
    f_addr = 32'h0;
    l_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_order", 64'(got_f), 64'(i % 2 == 0));
    end
    idle();
    step();

    // Fetch only, back-to-back
    f_req  = 1'b1;
    f_addr = 32'h8;
    for (int i = 0; i < 4; i++)
      step();
    idle();
    step();

    // Loader write, then fetch the same word
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 32'h10;
    l_wdata = 32'hDEADBEEF;
    step();
    idle();
    f_req  = 1'b1;
    f_addr = 32'h10;
    step();
    idle();
    step();
    chk("wr_then_rd", 64'(pd), 64'(0));

    // Errors: misaligned fetch, out-of-range loader read and write
    f_req  = 1'b1;
    f_addr = 32'h6;
    step();
    idle();
    l_req  = 1'b1;
    l_addr = 32'(4 * NI);
    step();
    l_we    = 1'b1;
    l_wdata = 32'h12345678;
    step();
    idle();
    step();

    // Lock holds fetch off, release grants it the same cycle
    l_lock = 1'b1;
    f_req  = 1'b1;
    f_addr = 32'h20;
    for (int i = 0; i < 10; i++)
      step();
    l_lock = 1'b0;
    step();
    chk("unlock_gnt", 64'(got_f), 64'(1));
    idle();
    step();

    // Reset with a response in flight
    f_req  = 1'b1;
    f_addr = 32'hC;
    step();
    do_reset();
    step();
    step();

    // Random traffic honouring hold-until-grant
    got_f = 1'b1;
    got_l = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!f_req || got_f) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = gen_addr();
      end
      if (!l_req || got_l) begin
        l_req   = ($urandom_range(0, 2) == 0);
        l_we    = $urandom_range(0, 1) == 1;
        l_addr  = gen_addr();
        l_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0)
        l_lock = ~l_lock;
      step();
    end
    idle();
    step();
    step();

    for (int i = 0; i < NI; i++)
      chk("mem_final", 64'(mem[i]), 64'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
